// File: rtl/led_pattern_pkg.sv
// Shared constants for the LED pattern generator and its step timer.
package led_pattern_pkg;

    localparam logic [1:0] MODE_BOUNCE = 2'd0;
    localparam logic [1:0] MODE_ROTATE = 2'd1;
    localparam logic [1:0] MODE_BINARY = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    localparam int SPEED_W = 2;

endpackage

// File: rtl/led_pattern_gen_step_timer.sv
// Step timer: counts enabled cycles, fires when the count reaches period-1.
// Latency: fire is combinational; strobe rises on the edge that acts on fire.
// Backpressure: none; en low freezes the count, clr restarts it without a strobe.
module step_timer #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W:0]   period,
    output logic             fire,
    output logic             strobe
);

    localparam logic [CNT_W:0]   ONE_P = (CNT_W + 1)'(1);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic [CNT_W-1:0] tick_cnt;

    // >= so that shortening the period below the current count steps immediately
    assign fire = en && !clr && ({1'b0, tick_cnt} >= (period - ONE_P));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tick_cnt <= '0;
            strobe   <= 1'b0;
        end else if (fire) begin
            tick_cnt <= '0;
            strobe   <= 1'b1;
        end else if (en) begin
            tick_cnt <= tick_cnt + ONE_C;
            strobe   <= 1'b0;
        end else begin
            strobe   <= 1'b0;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: bounce/rotate/binary/blink with PWM fading trail.
// Latency: pattern registers update with step_strobe; y follows one cycle later.
// Backpressure: none; en low blanks y and freezes timer, pattern and intensities.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int N_LEDS        = 4,
    parameter int P_BASE_PERIOD = 4_000_000,
    parameter int P_PWM_BITS    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [SPEED_W-1:0] speed_sel,
    input  logic               trail_en,
    output logic [N_LEDS-1:0]  y,
    output logic               step_strobe
);

    localparam int CNT_W = $clog2(P_BASE_PERIOD << 3);
    localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

    localparam logic [POS_W-1:0]      POS_MAX = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0]      POS_ONE = POS_W'(1);
    localparam logic [N_LEDS-1:0]     CNT_ONE = N_LEDS'(1);
    localparam logic [P_PWM_BITS-1:0] PWM_ONE = P_PWM_BITS'(1);
    localparam logic [P_PWM_BITS-1:0] I_MAX   = '1;

    logic [CNT_W:0]          period;
    logic                    fire;
    logic                    mode_chg;
    logic                    spot_mode;
    logic [1:0]              mode_q;
    logic [P_PWM_BITS-1:0]   pwm_cnt;

    logic [POS_W-1:0]        pos, pos_nxt;
    logic                    dir, dir_nxt;
    logic [N_LEDS-1:0]       cnt, cnt_nxt;
    logic                    blink, blink_nxt;

    assign period    = (CNT_W + 1)'(P_BASE_PERIOD) << speed_sel;
    assign mode_chg  = (mode != mode_q);
    assign spot_mode = (mode == MODE_BOUNCE) || (mode == MODE_ROTATE);

    step_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .clr    (mode_chg),
        .period (period),
        .fire   (fire),
        .strobe (step_strobe)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= mode;
            pwm_cnt <= '0;
            pos     <= '0;
            dir     <= 1'b0;
            cnt     <= '0;
            blink   <= 1'b0;
        end else begin
            mode_q  <= mode;
            pwm_cnt <= pwm_cnt + PWM_ONE;
            if (mode_chg) begin
                pos   <= '0;
                dir   <= 1'b0;
                cnt   <= '0;
                blink <= 1'b0;
            end else if (fire) begin
                pos   <= pos_nxt;
                dir   <= dir_nxt;
                cnt   <= cnt_nxt;
                blink <= blink_nxt;
            end
        end
    end

    always_comb begin
        pos_nxt   = pos;
        dir_nxt   = dir;
        cnt_nxt   = cnt;
        blink_nxt = blink;
        case (mode)
            MODE_BOUNCE: begin
                // dir=0 counts up; each endpoint is shown for exactly one step
                if (N_LEDS > 1) begin
                    if (!dir) begin
                        if (pos == POS_MAX) begin
                            pos_nxt = pos - POS_ONE;
                            dir_nxt = 1'b1;
                        end else begin
                            pos_nxt = pos + POS_ONE;
                        end
                    end else begin
                        if (pos == '0) begin
                            pos_nxt = pos + POS_ONE;
                            dir_nxt = 1'b0;
                        end else begin
                            pos_nxt = pos - POS_ONE;
                        end
                    end
                end
            end
            MODE_ROTATE: pos_nxt   = (pos == POS_MAX) ? '0 : pos + POS_ONE;
            MODE_BINARY: cnt_nxt   = cnt + CNT_ONE;
            default:     blink_nxt = ~blink;
        endcase
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_led
        logic [P_PWM_BITS-1:0] inten, inten_nxt;
        logic                  lit_nxt;
        logic                  y_q;

        always_comb begin
            lit_nxt = 1'b0;
            case (mode)
                MODE_BOUNCE, MODE_ROTATE: lit_nxt = (pos_nxt == POS_W'(i));
                MODE_BINARY:              lit_nxt = cnt_nxt[i];
                default:                  lit_nxt = blink_nxt;
            endcase

            inten_nxt = inten;
            if (mode_chg) begin
                inten_nxt = (i == 0 && spot_mode) ? I_MAX : '0;
            end else if (fire) begin
                if (lit_nxt)
                    inten_nxt = I_MAX;
                else if (trail_en && spot_mode)
                    inten_nxt = inten >> 1;
                else
                    inten_nxt = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                inten <= (i == 0) ? I_MAX : '0;
                y_q   <= 1'b0;
            end else begin
                inten <= inten_nxt;
                y_q   <= en && (inten > pwm_cnt);
            end
        end

        assign y[i] = y_q;
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: three widths (4, 3, 1 LEDs) driven in lockstep,
// checked every cycle against a step-index model plus hand-computed patterns.
`timescale 1ns/1ps
module tb_led_pattern_gen;

    localparam int BP = 4;
    localparam int PB = 4;
    localparam int IMAX = (1 << PB) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       trail_en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [1:0] speed_sel = 2'd0;

    logic [3:0] y4;
    logic [2:0] y3;
    logic [0:0] y1;
    logic       s4, s3, s1;

    int n_chk = 0;
    int n_pass = 0;
    bit cmp_on = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(.N_LEDS(4), .P_BASE_PERIOD(BP), .P_PWM_BITS(PB)) u_n4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .speed_sel(speed_sel),
        .trail_en(trail_en), .y(y4), .step_strobe(s4));
    led_pattern_gen #(.N_LEDS(3), .P_BASE_PERIOD(BP), .P_PWM_BITS(PB)) u_n3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .speed_sel(speed_sel),
        .trail_en(trail_en), .y(y3), .step_strobe(s3));
    led_pattern_gen #(.N_LEDS(1), .P_BASE_PERIOD(BP), .P_PWM_BITS(PB)) u_n1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .speed_sel(speed_sel),
        .trail_en(trail_en), .y(y1), .step_strobe(s1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- model: pattern as a function of steps since restart
    int       nl[3] = '{4, 3, 1};
    int       m_int[3][16];
    int       m_y[3];
    int       m_tick, m_k, m_pwm;
    bit       m_strobe;
    logic [1:0] m_mode_q;

    function automatic int lit_mask(input int n, input int k, input logic [1:0] md);
        int r;
        int p;
        p = 0;
        case (md)
            2'd0: begin
                if (n > 1) begin
                    r = k % (2 * n - 2);
                    p = (r < n) ? r : 2 * n - 2 - r;
                end
                return 1 << p;
            end
            2'd1:    return 1 << (k % n);
            2'd2:    return k % (1 << n);
            default: return (k % 2 == 1) ? (1 << n) - 1 : 0;
        endcase
    endfunction

    always @(posedge clk) begin : mdl
        int per;
        int msk;
        int v;
        for (int d = 0; d < 3; d++) begin
            v = 0;
            for (int i = 0; i < nl[d]; i++)
                if (!rst && en && m_int[d][i] > m_pwm) v |= (1 << i);
            m_y[d] = v;
        end
        if (rst) begin
            m_tick = 0; m_k = 0; m_pwm = 0; m_strobe = 0; m_mode_q = mode;
            for (int d = 0; d < 3; d++)
                for (int i = 0; i < 16; i++) m_int[d][i] = (i == 0) ? IMAX : 0;
        end else begin
            per = BP << speed_sel;
            m_pwm = (m_pwm + 1) % (1 << PB);
            m_strobe = 0;
            if (mode != m_mode_q) begin
                m_tick = 0; m_k = 0;
                for (int d = 0; d < 3; d++)
                    for (int i = 0; i < 16; i++)
                        m_int[d][i] = (i == 0 && mode < 2) ? IMAX : 0;
            end else if (en) begin
                if (m_tick >= per - 1) begin
                    m_tick = 0; m_strobe = 1; m_k++;
                    for (int d = 0; d < 3; d++) begin
                        msk = lit_mask(nl[d], m_k, mode);
                        for (int i = 0; i < nl[d]; i++)
                            if (msk[i]) m_int[d][i] = IMAX;
                            else if (trail_en && mode < 2) m_int[d][i] = m_int[d][i] >> 1;
                            else m_int[d][i] = 0;
                    end
                end else begin
                    m_tick++;
                end
            end
            m_mode_q = mode;
        end
    end

    initial begin
        @(posedge clk);
        cmp_on = 1;
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("y_n4", y4, m_y[0]);
            chk("y_n3", y3, m_y[1]);
            chk("y_n1", y1, m_y[2]);
            chk("strobe_n4", s4, m_strobe);
            chk("strobe_n3", s3, m_strobe);
            chk("strobe_n1", s1, m_strobe);
        end
    end

    // ---------------- directed stimulus with literal expectations
    int exp_b4[4]   = '{2, 4, 8, 4};
    int exp_r6[6]   = '{2, 4, 8, 4, 2, 1};
    int exp_rot4[4] = '{2, 4, 8, 1};
    int exp_rot3[4] = '{2, 4, 1, 2};
    int exp_bin3[8] = '{1, 2, 3, 4, 5, 6, 7, 0};
    int exp_tr4[4]  = '{3, 7, 15, 0};
    int exp_tr3[3]  = '{3, 7, 15};

    task automatic wait_strobe(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (s4 !== 1'b1 && n < 300);
        if (s4 !== 1'b1) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic cap_step(output logic [3:0] o4, output logic [2:0] o3, output logic o1);
        int n;
        wait_strobe("cap", n);
        o4 = '0; o3 = '0; o1 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            o4 |= y4; o3 |= y3; o1 |= y1[0];
        end
    endtask

    initial begin
        logic [3:0] c4;
        logic [2:0] c3;
        logic       c1;
        int         n;
        int         bad;
        int         d4[4];
        int         d3[3];

        repeat (3) @(negedge clk);
        chk("rst_y4", y4, 0);
        chk("rst_y1", y1, 0);
        chk("rst_strobe", s4, 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            cap_step(c4, c3, c1);
            chk("bounce_n4", c4, exp_b4[i]);
            chk("bounce_n1", c1, 1);
        end

        // now pos=2 heading down
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_y4", y4, 0);
        chk("midrst_strobe", s4, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cap_step(c4, c3, c1);
            chk("bounce_after_rst", c4, exp_r6[i]);
        end

        mode = 2'd1;
        for (int i = 0; i < 4; i++) begin
            cap_step(c4, c3, c1);
            chk("rotate_n4", c4, exp_rot4[i]);
            chk("rotate_n3", c3, exp_rot3[i]);
        end

        mode = 2'd2;
        for (int i = 0; i < 8; i++) begin
            cap_step(c4, c3, c1);
            chk("binary_n3", c3, exp_bin3[i]);
            chk("binary_n4", c4, i + 1);
        end

        // mode change landing on the terminal count
        n = 0;
        while (m_tick != BP - 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("term_align", m_tick, BP - 1);
        mode = 2'd0;
        trail_en = 1'b1;
        speed_sel = 2'd3;
        @(negedge clk);
        chk("modechg_no_strobe", s4, 0);
        c4 = '0; c3 = '0;
        repeat (3) begin
            @(negedge clk);
            c4 |= y4; c3 |= y3;
        end
        chk("modechg_pos0_n4", c4, 1);
        chk("modechg_pos0_n3", c3, 1);

        wait_strobe("trail1", n);
        wait_strobe("trail2", n);
        d4 = '{0, 0, 0, 0};
        d3 = '{0, 0, 0};
        repeat (16) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) d4[i] += y4[i];
            for (int i = 0; i < 3; i++) d3[i] += y3[i];
        end
        for (int i = 0; i < 4; i++) chk("trail_duty_n4", d4[i], exp_tr4[i]);
        for (int i = 0; i < 3; i++) chk("trail_duty_n3", d3[i], exp_tr3[i]);

        trail_en = 1'b0;
        speed_sel = 2'd2;
        n = 0;
        while (m_tick != 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tick10_align", m_tick, 10);
        speed_sel = 2'd0;
        @(negedge clk);
        chk("speed_immediate_strobe", s4, 1);
        wait_strobe("speed_period", n);
        chk("speed_new_period", n, 4);

        @(negedge clk);
        en = 1'b0;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (y4 !== 4'd0 || y3 !== 3'd0 || y1 !== 1'b0 || s4 !== 1'b0) bad++;
        end
        chk("freeze_quiet", bad, 0);
        en = 1'b1;
        wait_strobe("resume", n);
        chk("resume_remaining", n, 3);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
